decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, parametrised successor to the combinational instruction decoder. It accepts fetched instructions and their PC over a valid/ready handshake, decodes an extended RV32I subset, and presents the decoded bundle to execute through a two-entry skid buffer. Because in_ready is registered, the fetch→execute path is timing-decoupled. The block also supports pipeline flush and keeps a saturating illegal-instruction counter.

Parameters:
REG_ADDRW, 3, register index width; instr fields are truncated to their low REG_ADDRW bits (1..5)
EXT_OPS, 1, 1 decodes and/or/xor/slt/sll/srl/sra (R and I forms), bne, jalr, lui, auipc; 0 decodes only add/sub/addi/lw/sw/beq/jal
ILL_CNTW, 8, width of illegal-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage can accept (registered)
in_instr  in  32  instruction word
in_pc  in  32  instruction PC
flush  in  1  discard all held entries
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  32  PC of presented bundle
rs1_idx, rs2_idx, rd_idx  out  REG_ADDRW each  register indices
imm  out  32  sign-extended immediate (U-type: instr[31:12]<<12)
uses_rs1, uses_rs2, writes_rd  out  1 each  operand and writeback usage
alu_op, wb_sel, pc_sel, instr_type  out  riscv_defs enums  semantic controls
is_load, is_store, is_branch, is_jump  out  1 each  class flags
illegal  out  1  bundle is an undecodable instruction
ill_count  out  ILL_CNTW  illegal instructions accepted, saturating

Behaviour:
- riscv_defs gains ALU_AND/OR/XOR/SLT/SLL/SRL/SRA, WB_IMM (lui), PC_JALR (jalr), PC_BRANCH_NE (bne).
- Reset (async, rst_n=0): out_valid=0, in_ready=1, ill_count=0. All bundle fields reset to the NOP default: ALU_PASS, WB_NONE, PC_PLUS_4, INSTR_I, flags 0, imm 0, indices 0, out_pc 0, illegal 0.
- Decode is combinational on in_instr. The result is captured only on accept (in_valid & in_ready). Latency is 1 cycle when the stage is empty.
- Storage: main register (drives outputs) plus skid register.
  - in_ready = !skid_valid.
  - Accept with main empty, or main draining (out_ready) and no skid → write main.
  - Accept while main holds and !out_ready → write skid.
  - On out_valid & out_ready: skid moves to main, else main clears unless refilled by the same-cycle accept.
- Order preserved; no bubble between back-to-back accepts when out_ready=1 continuously, so throughput is 1/cycle.
- Output stability: while out_valid & !out_ready, every output holds unchanged.
- Illegal: unknown opcode, funct3 or funct7 (and EXT_OPS=0 extended ops) → illegal=1 with valid bundle, writes_rd=0, uses_*=0, NOP controls. illegal is still delivered downstream.
- ill_count increments once per accepted illegal instruction and saturates at 2^ILL_CNTW-1. It is not cleared by flush.
- Shift-immediate: funct7 must be 0x00 (0x20 for srai), otherwise illegal.
- flush: the next edge clears main and skid (out_valid=0, in_ready=1). An instruction offered in the flush cycle is dropped: not accepted, not counted. Flush beats a simultaneous out handshake.
- Reset mid-operation discards all entries immediately.

Test Plan:
- Reset, then offer 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle out_valid=1, rd_idx=1, imm=5, ALU_ADD, WB_ALU, writes_rd=1; in_ready stays 1.
- Stream add 0x002081B3, sub 0x402081B3, lw 0x00812283, sw 0x00512623, in_pc 0,4,8,12 back-to-back with out_ready=1 → four consecutive out_valid cycles in order. Expect ALU_ADD/ALU_SUB; lw imm=8 is_load; sw imm=12 is_store uses_rs2; no bubbles.
- Hold out_ready=0 and offer beq 0xFE208EE3 then jal 0x008000EF → both accepted, in_ready=0 after the second, outputs frozen on beq (imm=0xFFFFFFFC). out_ready=1 → jal next (imm=8, WB_PC4, is_jump), then in_ready returns to 1.
- EXT_OPS=1: lui 0x123450B7 → imm=0x12345000, WB_IMM; and 0x0020F1B3 → ALU_AND. EXT_OPS=0 same words → illegal=1, ill_count=2.
- Offer 0xFFFFFFFF 300 times with ILL_CNTW=8 → ill_count saturates at 255; each bundle has illegal=1 and writes_rd=0.
- Fill main and skid, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, offered instruction never appears; ill_count unchanged.

Source files
------------

// File: rtl/decode_stage.sv
// Registered RV32I-subset decode stage: decodes fetched instructions on accept and
// presents them to execute through a two-entry skid buffer, with flush and illegal counting.
package riscv_defs;
    typedef enum logic [3:0] {
        ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
        ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;
    typedef enum logic [2:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;
    typedef enum logic [2:0] {PC_PLUS_4, PC_BRANCH, PC_JAL, PC_JALR, PC_BRANCH_NE} pc_sel_e;
    typedef enum logic [2:0] {INSTR_I, INSTR_R, INSTR_S, INSTR_B, INSTR_U, INSTR_J} instr_type_e;
endpackage

module decode_stage
    import riscv_defs::*;
#(
    parameter int REG_ADDRW = 3,
    parameter int EXT_OPS   = 1,
    parameter int ILL_CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [REG_ADDRW-1:0] rs1_idx,
    output logic [REG_ADDRW-1:0] rs2_idx,
    output logic [REG_ADDRW-1:0] rd_idx,
    output logic [31:0]          imm,
    output logic                 uses_rs1,
    output logic                 uses_rs2,
    output logic                 writes_rd,
    output alu_op_e              alu_op,
    output wb_sel_e              wb_sel,
    output pc_sel_e              pc_sel,
    output instr_type_e          instr_type,
    output logic                 is_load,
    output logic                 is_store,
    output logic                 is_branch,
    output logic                 is_jump,
    output logic                 illegal,
    output logic [ILL_CNTW-1:0]  ill_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // All-zero encodes the NOP bundle: ALU_PASS, WB_NONE, PC_PLUS_4, INSTR_I.
    typedef struct packed {
        logic [31:0]          pc;
        logic [REG_ADDRW-1:0] rs1;
        logic [REG_ADDRW-1:0] rs2;
        logic [REG_ADDRW-1:0] rd;
        logic [31:0]          imm;
        logic                 uses_rs1;
        logic                 uses_rs2;
        logic                 writes_rd;
        alu_op_e              alu_op;
        wb_sel_e              wb_sel;
        pc_sel_e              pc_sel;
        instr_type_e          instr_type;
        logic                 is_load;
        logic                 is_store;
        logic                 is_branch;
        logic                 is_jump;
        logic                 illegal;
    } bundle_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sh;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm_sh = {27'b0, in_instr[24:20]};

    bundle_t dec;
    logic    legal;
    logic    ext_op;

    // Shift-immediate forms carry only the shamt as their immediate.
    always_comb begin
        dec    = '0;
        legal  = 1'b1;
        ext_op = 1'b0;
        dec.rs1 = in_instr[15 +: REG_ADDRW];
        dec.rs2 = in_instr[20 +: REG_ADDRW];
        dec.rd  = in_instr[7 +: REG_ADDRW];
        case (opcode)
            OPC_OP: begin
                dec.instr_type = INSTR_R;
                dec.uses_rs1   = 1'b1;
                dec.uses_rs2   = 1'b1;
                dec.writes_rd  = 1'b1;
                dec.wb_sel     = WB_ALU;
                ext_op         = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: begin dec.alu_op = ALU_ADD; ext_op = 1'b0; end
                    {7'h20, 3'b000}: begin dec.alu_op = ALU_SUB; ext_op = 1'b0; end
                    {7'h00, 3'b001}: dec.alu_op = ALU_SLL;
                    {7'h00, 3'b010}: dec.alu_op = ALU_SLT;
                    {7'h00, 3'b100}: dec.alu_op = ALU_XOR;
                    {7'h00, 3'b101}: dec.alu_op = ALU_SRL;
                    {7'h20, 3'b101}: dec.alu_op = ALU_SRA;
                    {7'h00, 3'b110}: dec.alu_op = ALU_OR;
                    {7'h00, 3'b111}: dec.alu_op = ALU_AND;
                    default:         legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec.instr_type = INSTR_I;
                dec.uses_rs1   = 1'b1;
                dec.writes_rd  = 1'b1;
                dec.wb_sel     = WB_ALU;
                dec.imm        = imm_i;
                ext_op         = (funct3 != 3'b000);
                case (funct3)
                    3'b000: dec.alu_op = ALU_ADD;
                    3'b010: dec.alu_op = ALU_SLT;
                    3'b100: dec.alu_op = ALU_XOR;
                    3'b110: dec.alu_op = ALU_OR;
                    3'b111: dec.alu_op = ALU_AND;
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        dec.imm    = imm_sh;
                        legal      = (funct7 == 7'h00);
                    end
                    3'b101: begin
                        dec.imm = imm_sh;
                        if (funct7 == 7'h00) begin
                            dec.alu_op = ALU_SRL;
                        end else if (funct7 == 7'h20) begin
                            dec.alu_op = ALU_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.instr_type = INSTR_I;
                dec.uses_rs1   = 1'b1;
                dec.writes_rd  = 1'b1;
                dec.wb_sel     = WB_MEM;
                dec.alu_op     = ALU_ADD;
                dec.imm        = imm_i;
                dec.is_load    = 1'b1;
                legal          = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                dec.instr_type = INSTR_S;
                dec.uses_rs1   = 1'b1;
                dec.uses_rs2   = 1'b1;
                dec.alu_op     = ALU_ADD;
                dec.imm        = imm_s;
                dec.is_store   = 1'b1;
                legal          = (funct3 == 3'b010);
            end
            OPC_BRANCH: begin
                dec.instr_type = INSTR_B;
                dec.uses_rs1   = 1'b1;
                dec.uses_rs2   = 1'b1;
                dec.alu_op     = ALU_SUB;
                dec.imm        = imm_b;
                dec.is_branch  = 1'b1;
                if (funct3 == 3'b000) begin
                    dec.pc_sel = PC_BRANCH;
                end else if (funct3 == 3'b001) begin
                    dec.pc_sel = PC_BRANCH_NE;
                    ext_op     = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_JAL: begin
                dec.instr_type = INSTR_J;
                dec.writes_rd  = 1'b1;
                dec.wb_sel     = WB_PC4;
                dec.pc_sel     = PC_JAL;
                dec.alu_op     = ALU_ADD;
                dec.imm        = imm_j;
                dec.is_jump    = 1'b1;
            end
            OPC_JALR: begin
                dec.instr_type = INSTR_I;
                dec.uses_rs1   = 1'b1;
                dec.writes_rd  = 1'b1;
                dec.wb_sel     = WB_PC4;
                dec.pc_sel     = PC_JALR;
                dec.alu_op     = ALU_ADD;
                dec.imm        = imm_i;
                dec.is_jump    = 1'b1;
                ext_op         = 1'b1;
                legal          = (funct3 == 3'b000);
            end
            OPC_LUI: begin
                dec.instr_type = INSTR_U;
                dec.writes_rd  = 1'b1;
                dec.wb_sel     = WB_IMM;
                dec.alu_op     = ALU_PASS;
                dec.imm        = imm_u;
                ext_op         = 1'b1;
            end
            OPC_AUIPC: begin
                dec.instr_type = INSTR_U;
                dec.writes_rd  = 1'b1;
                dec.wb_sel     = WB_ALU;
                dec.alu_op     = ALU_ADD;
                dec.imm        = imm_u;
                ext_op         = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (ext_op && (EXT_OPS == 0)) begin
            legal = 1'b0;
        end
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.pc = in_pc;
    end

    bundle_t main_q;
    bundle_t skid_q;
    logic    main_valid;
    logic    skid_valid;
    logic    accept;

    assign accept = in_valid && in_ready && !flush;

    // Main drives the outputs; skid only fills while main is stalled, so in_ready is one flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ill_count  <= '0;
        end else begin
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (main_valid && out_ready) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_q <= dec;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                if (!main_valid) begin
                    main_q     <= dec;
                    main_valid <= 1'b1;
                end else begin
                    skid_q     <= dec;
                    skid_valid <= 1'b1;
                end
            end
            if (accept && dec.illegal && (ill_count != '1)) begin
                ill_count <= ill_count + 1'b1;
            end
        end
    end

    assign in_ready   = !skid_valid;
    assign out_valid  = main_valid;
    assign out_pc     = main_q.pc;
    assign rs1_idx    = main_q.rs1;
    assign rs2_idx    = main_q.rs2;
    assign rd_idx     = main_q.rd;
    assign imm        = main_q.imm;
    assign uses_rs1   = main_q.uses_rs1;
    assign uses_rs2   = main_q.uses_rs2;
    assign writes_rd  = main_q.writes_rd;
    assign alu_op     = main_q.alu_op;
    assign wb_sel     = main_q.wb_sel;
    assign pc_sel     = main_q.pc_sel;
    assign instr_type = main_q.instr_type;
    assign is_load    = main_q.is_load;
    assign is_store   = main_q.is_store;
    assign is_branch  = main_q.is_branch;
    assign is_jump    = main_q.is_jump;
    assign illegal    = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a random stream checked
// against an opcode-table decoder and a FIFO model of the stage occupancy.
module tb_decode_stage;
    import riscv_defs::*;

    localparam int ILL_MAX = 255;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [2:0]  rd;
        logic [31:0] imm;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        alu_op_e     alu_op;
        wb_sel_e     wb_sel;
        pc_sel_e     pc_sel;
        instr_type_e instr_type;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, uses_rs1, uses_rs2, writes_rd;
    logic        is_load, is_store, is_branch, is_jump, illegal;
    logic [31:0] out_pc, imm;
    logic [2:0]  rs1_idx, rs2_idx, rd_idx;
    logic [7:0]  ill_count;
    alu_op_e     alu_op;
    wb_sel_e     wb_sel;
    pc_sel_e     pc_sel;
    instr_type_e instr_type;

    logic        in_ready_b, out_valid_b, uses_rs1_b, uses_rs2_b, writes_rd_b;
    logic        is_load_b, is_store_b, is_branch_b, is_jump_b, illegal_b;
    logic [31:0] out_pc_b, imm_b;
    logic [2:0]  rs1_idx_b, rs2_idx_b, rd_idx_b;
    logic [7:0]  ill_count_b;
    alu_op_e     alu_op_b;
    wb_sel_e     wb_sel_b;
    pc_sel_e     pc_sel_b;
    instr_type_e instr_type_b;

    decode_stage #(.REG_ADDRW(3), .EXT_OPS(1), .ILL_CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rd_idx(rd_idx), .imm(imm), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
        .writes_rd(writes_rd), .alu_op(alu_op), .wb_sel(wb_sel), .pc_sel(pc_sel),
        .instr_type(instr_type), .is_load(is_load), .is_store(is_store),
        .is_branch(is_branch), .is_jump(is_jump), .illegal(illegal), .ill_count(ill_count)
    );

    decode_stage #(.REG_ADDRW(3), .EXT_OPS(0), .ILL_CNTW(8)) dut_base (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_pc(out_pc_b), .rs1_idx(rs1_idx_b), .rs2_idx(rs2_idx_b),
        .rd_idx(rd_idx_b), .imm(imm_b), .uses_rs1(uses_rs1_b), .uses_rs2(uses_rs2_b),
        .writes_rd(writes_rd_b), .alu_op(alu_op_b), .wb_sel(wb_sel_b), .pc_sel(pc_sel_b),
        .instr_type(instr_type_b), .is_load(is_load_b), .is_store(is_store_b),
        .is_branch(is_branch_b), .is_jump(is_jump_b), .illegal(illegal_b),
        .ill_count(ill_count_b)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    int          exp_cnt = 0;
    logic [31:0] tab_mask  [25];
    logic [31:0] tab_match [25];
    string       tab_name  [25];
    bit          tab_base  [25];

    // Mask/match opcode table in the style of the ISA manual; base ops exist without EXT_OPS.
    task automatic setup_tables();
        tab_name  = '{"add", "sub", "sll", "slt", "xor", "srl", "sra", "or", "and",
                      "addi", "slti", "xori", "ori", "andi", "slli", "srli", "srai",
                      "lw", "sw", "beq", "bne", "jalr", "jal", "lui", "auipc"};
        tab_match = '{32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00004033,
                      32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033,
                      32'h00000013, 32'h00002013, 32'h00004013, 32'h00006013, 32'h00007013,
                      32'h00001013, 32'h00005013, 32'h40005013,
                      32'h00002003, 32'h00002023, 32'h00000063, 32'h00001063, 32'h00000067,
                      32'h0000006F, 32'h00000037, 32'h00000017};
        tab_mask  = '{32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
                      32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
                      32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
                      32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
                      32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
                      32'h0000007F, 32'h0000007F, 32'h0000007F};
        tab_base  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                      1, 1, 1, 0, 0, 1, 0, 0};
    endtask

    function automatic alu_op_e alu_of(input string b);
        if (b == "add") return ALU_ADD;
        if (b == "sub") return ALU_SUB;
        if (b == "and") return ALU_AND;
        if (b == "or")  return ALU_OR;
        if (b == "xor") return ALU_XOR;
        if (b == "slt") return ALU_SLT;
        if (b == "sll") return ALU_SLL;
        if (b == "srl") return ALU_SRL;
        if (b == "sra") return ALU_SRA;
        return ALU_PASS;
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, input bit ext);
        exp_t  e;
        string m;
        bit    r_form, i_form, shift;
        e    = '0;
        e.pc = pc;
        m    = "illegal";
        for (int i = 0; i < 25; i++) begin
            if (m == "illegal" && (w & tab_mask[i]) == tab_match[i] && (ext || tab_base[i]))
                m = tab_name[i];
        end
        if (m == "illegal") begin
            e.illegal = 1'b1;
            return e;
        end
        e.rs1 = w[17:15];
        e.rs2 = w[22:20];
        e.rd  = w[9:7];
        r_form = (m == "add" || m == "sub" || m == "sll" || m == "slt" || m == "xor" ||
                  m == "srl" || m == "sra" || m == "or" || m == "and");
        shift  = (m == "slli" || m == "srli" || m == "srai");
        i_form = shift || m == "addi" || m == "slti" || m == "xori" || m == "ori" || m == "andi";
        if (r_form || i_form) begin
            e.instr_type = r_form ? INSTR_R : INSTR_I;
            e.uses_rs1   = 1'b1;
            e.uses_rs2   = r_form;
            e.writes_rd  = 1'b1;
            e.wb_sel     = WB_ALU;
            e.alu_op     = alu_of(i_form ? m.substr(0, m.len() - 2) : m);
            if (i_form) e.imm = shift ? {27'b0, w[24:20]} : {{20{w[31]}}, w[31:20]};
        end else if (m == "lw") begin
            e.uses_rs1 = 1'b1; e.writes_rd = 1'b1; e.wb_sel = WB_MEM; e.alu_op = ALU_ADD;
            e.is_load = 1'b1; e.imm = {{20{w[31]}}, w[31:20]};
        end else if (m == "sw") begin
            e.instr_type = INSTR_S; e.uses_rs1 = 1'b1; e.uses_rs2 = 1'b1; e.alu_op = ALU_ADD;
            e.is_store = 1'b1; e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        end else if (m == "beq" || m == "bne") begin
            e.instr_type = INSTR_B; e.uses_rs1 = 1'b1; e.uses_rs2 = 1'b1; e.alu_op = ALU_SUB;
            e.is_branch = 1'b1; e.pc_sel = (m == "beq") ? PC_BRANCH : PC_BRANCH_NE;
            e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        end else if (m == "jal" || m == "jalr") begin
            e.instr_type = (m == "jal") ? INSTR_J : INSTR_I;
            e.uses_rs1 = (m == "jalr"); e.writes_rd = 1'b1; e.wb_sel = WB_PC4;
            e.alu_op = ALU_ADD; e.is_jump = 1'b1;
            e.pc_sel = (m == "jal") ? PC_JAL : PC_JALR;
            e.imm = (m == "jal") ? {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}
                                 : {{20{w[31]}}, w[31:20]};
        end else begin
            e.instr_type = INSTR_U; e.writes_rd = 1'b1; e.imm = {w[31:12], 12'b0};
            e.wb_sel = (m == "lui") ? WB_IMM : WB_ALU;
            e.alu_op = (m == "lui") ? ALU_PASS : ALU_ADD;
        end
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.pc = out_pc; o.rs1 = rs1_idx; o.rs2 = rs2_idx; o.rd = rd_idx; o.imm = imm;
        o.uses_rs1 = uses_rs1; o.uses_rs2 = uses_rs2; o.writes_rd = writes_rd;
        o.alu_op = alu_op; o.wb_sel = wb_sel; o.pc_sel = pc_sel; o.instr_type = instr_type;
        o.is_load = is_load; o.is_store = is_store; o.is_branch = is_branch;
        o.is_jump = is_jump; o.illegal = illegal;
        return o;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          r;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h6F;
            6: w[6:0] = 7'h67;
            7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17;
            default: ;
        endcase
        r = $urandom_range(0, 3);
        if (r == 0) w[31:25] = 7'h00;
        else if (r == 1) w[31:25] = 7'h20;
        if ($urandom_range(0, 2) == 0) w[14:12] = 3'b010;
        else if ($urandom_range(0, 2) == 0) w[14:12] = 3'b000;
        return w;
    endfunction

    // Drives one cycle of inputs, advances the occupancy model across the edge, lands on negedge.
    task automatic step(input bit v, input logic [31:0] w, input logic [31:0] pc,
                        input bit ordy, input bit fl);
        bit   pop, push;
        exp_t e;
        in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
        if (fl) begin
            q.delete();
        end else begin
            pop  = (q.size() > 0) && ordy;
            push = v && (q.size() < 2);
            if (pop) void'(q.pop_front());
            if (push) begin
                e = model(w, pc, 1'b1);
                q.push_back(e);
                if (e.illegal && exp_cnt < ILL_MAX) exp_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        q.delete(); exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_hs got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        checks++;
        if (ill_count !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_cnt got %0d want 0", ill_count);
        end
        checks++;
        if (observe() !== exp_t'('0)) begin
            errors++; $display("[TB] FAIL reset_bundle got %h want 0", observe());
        end
        rst_n = 1'b1;
        q.delete(); exp_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_addi();
        do_reset();
        step(1, 32'h00500093, 32'h0, 1, 0);
        checks++;
        if (out_valid !== 1'b1 || rd_idx !== 3'd1 || imm !== 32'd5 || writes_rd !== 1'b1) begin
            errors++; $display("[TB] FAIL addi got v=%b rd=%0d imm=%h wr=%b want 1 1 5 1", out_valid, rd_idx, imm, writes_rd);
        end
        checks++;
        if (alu_op !== ALU_ADD || wb_sel !== WB_ALU || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL addi_ctl got alu=%0d wb=%0d rdy=%b", alu_op, wb_sel, in_ready);
        end
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_stream();
        logic [31:0] words [4];
        alu_op_e     alus  [4];
        logic [31:0] imms  [4];
        words = '{32'h002081B3, 32'h402081B3, 32'h00812283, 32'h00512623};
        alus  = '{ALU_ADD, ALU_SUB, ALU_ADD, ALU_ADD};
        imms  = '{32'd0, 32'd0, 32'd8, 32'd12};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, words[i], 32'(i * 4), 1, 0);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || alu_op !== alus[i] || imm !== imms[i]) begin
                errors++; $display("[TB] FAIL stream%0d got v=%b pc=%h alu=%0d imm=%h", i, out_valid, out_pc, alu_op, imm);
            end
            checks++;
            if (q.size() == 0 || observe() !== q[0]) begin
                errors++; $display("[TB] FAIL stream_bundle%0d got %h", i, observe());
            end
        end
        checks++;
        if (is_store !== 1'b1 || uses_rs2 !== 1'b1) begin
            errors++; $display("[TB] FAIL stream_sw got st=%b rs2u=%b want 1 1", is_store, uses_rs2);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL stream_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_skid();
        do_reset();
        step(1, 32'hFE208EE3, 32'h40, 0, 0);
        step(1, 32'h008000EF, 32'h44, 0, 0);
        checks++;
        if (in_ready !== 1'b0 || out_pc !== 32'h40 || imm !== 32'hFFFFFFFC || is_branch !== 1'b1) begin
            errors++; $display("[TB] FAIL skid_full got rdy=%b pc=%h imm=%h br=%b", in_ready, out_pc, imm, is_branch);
        end
        step(1, 32'h00000013, 32'h48, 0, 0);
        checks++;
        if (q.size() == 0 || observe() !== q[0] || out_pc !== 32'h40) begin
            errors++; $display("[TB] FAIL skid_hold got %h", observe());
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (out_pc !== 32'h44 || imm !== 32'd8 || wb_sel !== WB_PC4 || is_jump !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL skid_jal got pc=%h imm=%h wb=%0d j=%b rdy=%b", out_pc, imm, wb_sel, is_jump, in_ready);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL skid_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_ext();
        do_reset();
        step(1, 32'h123450B7, 32'h80, 1, 0);
        checks++;
        if (imm !== 32'h12345000 || wb_sel !== WB_IMM || illegal !== 1'b0) begin
            errors++; $display("[TB] FAIL ext_lui got imm=%h wb=%0d ill=%b", imm, wb_sel, illegal);
        end
        checks++;
        if (out_valid_b !== 1'b1 || illegal_b !== 1'b1 || writes_rd_b !== 1'b0) begin
            errors++; $display("[TB] FAIL base_lui got v=%b ill=%b wr=%b want 1 1 0", out_valid_b, illegal_b, writes_rd_b);
        end
        step(1, 32'h0020F1B3, 32'h84, 1, 0);
        checks++;
        if (alu_op !== ALU_AND || illegal_b !== 1'b1 || alu_op_b !== ALU_PASS) begin
            errors++; $display("[TB] FAIL ext_and got alu=%0d base_ill=%b base_alu=%0d", alu_op, illegal_b, alu_op_b);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (ill_count_b !== 8'd2 || ill_count !== 8'd0) begin
            errors++; $display("[TB] FAIL ext_cnt got base=%0d ext=%0d want 2 0", ill_count_b, ill_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1, 32'hFFFFFFFF, 32'(i * 4), 1, 0);
            checks++;
            if (out_valid !== 1'b1 || illegal !== 1'b1 || writes_rd !== 1'b0 || ill_count !== 8'(exp_cnt)) begin
                errors++; $display("[TB] FAIL sat%0d got v=%b ill=%b wr=%b cnt=%0d want cnt=%0d", i, out_valid, illegal, writes_rd, ill_count, exp_cnt);
            end
        end
        checks++;
        if (ill_count !== 8'd255) begin
            errors++; $display("[TB] FAIL sat_final got %0d want 255", ill_count);
        end
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_flush();
        do_reset();
        step(1, 32'hFFFFFFFF, 32'h200, 0, 0);
        step(1, 32'h002081B3, 32'h204, 0, 0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || ill_count !== 8'd1) begin
            errors++; $display("[TB] FAIL flush_fill got rdy=%b v=%b cnt=%0d", in_ready, out_valid, ill_count);
        end
        step(1, 32'h402081B3, 32'h208, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ill_count !== 8'd1) begin
            errors++; $display("[TB] FAIL flush_full got v=%b rdy=%b cnt=%0d want 0 1 1", out_valid, in_ready, ill_count);
        end
        step(1, 32'hFFFFFFFF, 32'h20C, 1, 1);
        step(0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0 || ill_count !== 8'd1) begin
            errors++; $display("[TB] FAIL flush_drop got v=%b cnt=%0d want 0 1", out_valid, ill_count);
        end
        step(1, 32'h002081B3, 32'h210, 0, 0);
        step(0, 0, 0, 1, 1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_vs_out got v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 32'hFFFFFFFF, 32'h300, 0, 0);
        step(1, 32'h00500093, 32'h304, 0, 0);
        #2 rst_n = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ill_count !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_mid got v=%b rdy=%b cnt=%0d want 0 1 0", out_valid, in_ready, ill_count);
        end
        q.delete(); exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        exp_t o;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFFFFFC,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
            checks++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
                errors++; $display("[TB] FAIL rand_hs%0d got rdy=%b v=%b want occupancy %0d", i, in_ready, out_valid, q.size());
            end
            if (q.size() > 0) begin
                o = observe();
                checks++;
                if (o !== q[0]) begin
                    errors++; $display("[TB] FAIL rand_bundle%0d got %h want %h", i, o, q[0]);
                end
            end
            checks++;
            if (ill_count !== 8'(exp_cnt)) begin
                errors++; $display("[TB] FAIL rand_cnt%0d got %0d want %0d", i, ill_count, exp_cnt);
            end
        end
    endtask

    initial begin
        setup_tables();
        test_reset();
        test_addi();
        test_stream();
        test_skid();
        test_ext();
        test_saturation();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
